// File: rtl/qft_serial_sched.sv
// 4-point QFT stage built around one shared complex MAC stepping through all 16 matrix terms.
// Latency: 16 cycles from input accept to out_valid; one vector every 18 cycles when the sink is always ready.
// Backpressure: in_ready only in IDLE; results are held in DONE until out_ready. Optional QFT_SAT_EN clamps instead of wrapping.
module qft_serial_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_r0,
  input  logic [7:0]  in_r1,
  input  logic [7:0]  in_r2,
  input  logic [7:0]  in_r3,
  input  logic [7:0]  in_i0,
  input  logic [7:0]  in_i1,
  input  logic [7:0]  in_i2,
  input  logic [7:0]  in_i3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_r0,
  output logic [12:0] out_r1,
  output logic [12:0] out_r2,
  output logic [12:0] out_r3,
  output logic [12:0] out_i0,
  output logic [12:0] out_i1,
  output logic [12:0] out_i2,
  output logic [12:0] out_i3,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         row_q, col_q;
  logic signed [7:0]  xr_q [4];
  logic signed [7:0]  xi_q [4];
  logic signed [23:0] acc_re_q, acc_im_q;
  logic [12:0]        yr_q [4];
  logic [12:0]        yi_q [4];
  logic               ovf_q;

  // Twiddle exponent: i^(row*col), only the low two bits matter.
  logic [1:0] m;
  assign m = row_q * col_q;

  logic signed [11:0] coef_c, coef_s;

  // Q2.10 twiddle lookup; the powers of i only ever need +/-1 and 0.
  always_comb begin
    coef_c = 12'sh000;
    coef_s = 12'sh000;
    case (m)
      2'd0: coef_c = 12'sh400;
      2'd1: coef_s = 12'sh400;
      2'd2: coef_c = 12'shC00;
      default: coef_s = 12'shC00;
    endcase
  end

  // Operands sign-extended to the product width so the multiplies stay signed.
  logic signed [19:0] xr_ext, xi_ext, c_ext, s_ext;
  logic signed [19:0] p_rc, p_is, p_rs, p_ic;
  assign xr_ext = {{12{xr_q[col_q][7]}}, xr_q[col_q]};
  assign xi_ext = {{12{xi_q[col_q][7]}}, xi_q[col_q]};
  assign c_ext  = {{8{coef_c[11]}}, coef_c};
  assign s_ext  = {{8{coef_s[11]}}, coef_s};
  assign p_rc   = xr_ext * c_ext;
  assign p_is   = xi_ext * s_ext;
  assign p_rs   = xr_ext * s_ext;
  assign p_ic   = xi_ext * c_ext;

  // Running sum including the current term; this is also the row result on the last column.
  logic signed [23:0] sum_re, sum_im;
  assign sum_re = acc_re_q + {{4{p_rc[19]}}, p_rc} - {{4{p_is[19]}}, p_is};
  assign sum_im = acc_im_q + {{4{p_rs[19]}}, p_rs} + {{4{p_ic[19]}}, p_ic};

  // Divide by two and drop Q10 to Q5 in one arithmetic shift (floors toward -inf).
  logic signed [23:0] sh_re, sh_im;
  assign sh_re = sum_re >>> 6;
  assign sh_im = sum_im >>> 6;

  // Returns {out_of_range, 13-bit result}; the range test is shared by both builds.
  function automatic logic [13:0] conv(input logic signed [23:0] v);
    logic        fits;
    logic [12:0] r;
    fits = (v[23:12] == {12{v[12]}});
`ifdef QFT_SAT_EN
    if (!fits) r = v[23] ? 13'h1000 : 13'h0FFF;
    else       r = v[12:0];
`else
    r = v[12:0];
`endif
    return {~fits, r};
  endfunction

  logic [13:0] cv_re, cv_im;
  assign cv_re = conv(sh_re);
  assign cv_im = conv(sh_im);

  logic last_term;
  assign last_term = (col_q == 2'd3) && (row_q == 2'd3);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_term) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, one MAC per CALC cycle, row result written on its last column.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q    <= 2'd0;
      col_q    <= 2'd0;
      acc_re_q <= 24'sd0;
      acc_im_q <= 24'sd0;
      ovf_q    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        xr_q[k] <= 8'sd0;
        xi_q[k] <= 8'sd0;
        yr_q[k] <= 13'd0;
        yi_q[k] <= 13'd0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            xr_q[0]  <= in_r0;
            xr_q[1]  <= in_r1;
            xr_q[2]  <= in_r2;
            xr_q[3]  <= in_r3;
            xi_q[0]  <= in_i0;
            xi_q[1]  <= in_i1;
            xi_q[2]  <= in_i2;
            xi_q[3]  <= in_i3;
            acc_re_q <= 24'sd0;
            acc_im_q <= 24'sd0;
            ovf_q    <= 1'b0;
            row_q    <= 2'd0;
            col_q    <= 2'd0;
          end
        end
        CALC: begin
          if (col_q == 2'd3) begin
            yr_q[row_q] <= cv_re[12:0];
            yi_q[row_q] <= cv_im[12:0];
            ovf_q       <= ovf_q | cv_re[13] | cv_im[13];
            acc_re_q    <= 24'sd0;
            acc_im_q    <= 24'sd0;
            col_q       <= 2'd0;
            row_q       <= row_q + 2'd1;
          end else begin
            acc_re_q <= sum_re;
            acc_im_q <= sum_im;
            col_q    <= col_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_r0 = yr_q[0];
  assign out_r1 = yr_q[1];
  assign out_r2 = yr_q[2];
  assign out_r3 = yr_q[3];
  assign out_i0 = yi_q[0];
  assign out_i1 = yi_q[1];
  assign out_i2 = yi_q[2];
  assign out_i3 = yi_q[3];
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_qft_serial_sched.sv
// Directed bench for qft_serial_sched: known vectors, handshake stall and mid-run reset.
module tb_qft_serial_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy, ovf;
  logic [7:0]  xr [4];
  logic [7:0]  xi [4];
  logic [12:0] o_r [4];
  logic [12:0] o_i [4];

  logic signed [12:0] er [4];
  logic signed [12:0] ei [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qft_serial_sched dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r0(xr[0]), .in_r1(xr[1]), .in_r2(xr[2]), .in_r3(xr[3]),
    .in_i0(xi[0]), .in_i1(xi[1]), .in_i2(xi[2]), .in_i3(xi[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r0(o_r[0]), .out_r1(o_r[1]), .out_r2(o_r[2]), .out_r3(o_r[3]),
    .out_i0(o_i[0]), .out_i1(o_i[1]), .out_i2(o_i[2]), .out_i3(o_i[3]),
    .busy(busy), .ovf(ovf)
  );

  task automatic load_vec(input int r0, input int i0, input int r1, input int i1,
                          input int r2, input int i2, input int r3, input int i3);
    xr[0] = r0[7:0]; xi[0] = i0[7:0];
    xr[1] = r1[7:0]; xi[1] = i1[7:0];
    xr[2] = r2[7:0]; xi[2] = i2[7:0];
    xr[3] = r3[7:0]; xi[3] = i3[7:0];
  endtask

  // Presents a vector from IDLE, returns cycles from accept edge until out_valid (capped at 40).
  task automatic run_vec(input int r0, input int i0, input int r1, input int i1,
                         input int r2, input int i2, input int r3, input int i3,
                         output int lat);
    @(negedge clk);
    load_vec(r0, i0, r1, i1, r2, i2, r3, i3);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    load_vec(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_r[k] !== 13'd0 || o_i[k] !== 13'd0) begin
        errors++; $display("FAIL reset_out%0d got (%0d,%0d) exp (0,0)", k, $signed(o_r[k]), $signed(o_i[k]));
      end
    end
    // Reset held while a vector is offered: nothing may be accepted.
    load_vec(3, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_vs_valid busy=%b in_ready=%b exp busy=0 in_ready=1", busy, in_ready);
    end
  endtask

  task automatic test_uniform();
    int lat;
    run_vec(1, 0, 1, 0, 1, 0, 1, 0, lat);
    er[0] = 64; ei[0] = 0; er[1] = 0; ei[1] = 0; er[2] = 0; ei[2] = 0; er[3] = 0; ei[3] = 0;
    checks++; if (lat !== 16) begin errors++; $display("FAIL uniform_latency got %0d exp 16", lat); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_r[k] !== er[k] || o_i[k] !== ei[k]) begin
        errors++; $display("FAIL uniform_out%0d got (%0d,%0d) exp (%0d,%0d)", k, $signed(o_r[k]), $signed(o_i[k]), er[k], ei[k]);
      end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL uniform_ovf got %b exp 0", ovf); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL uniform_done_flags busy=%b in_ready=%b exp 1/0", busy, in_ready);
    end
    release_out();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL uniform_to_idle out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_impulse();
    int lat;
    run_vec(10, 0, 0, 0, 0, 0, 0, 0, lat);
    for (int k = 0; k < 4; k++) begin er[k] = 160; ei[k] = 0; end
    checks++; if (lat !== 16) begin errors++; $display("FAIL impulse_latency got %0d exp 16", lat); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_r[k] !== er[k] || o_i[k] !== ei[k]) begin
        errors++; $display("FAIL impulse_out%0d got (%0d,%0d) exp (%0d,%0d)", k, $signed(o_r[k]), $signed(o_i[k]), er[k], ei[k]);
      end
    end
    release_out();
  endtask

  task automatic test_imag();
    int lat;
    run_vec(0, 0, 0, 8, 0, 0, 0, 0, lat);
    er[0] = 0;    ei[0] = 128;
    er[1] = -128; ei[1] = 0;
    er[2] = 0;    ei[2] = -128;
    er[3] = 128;  ei[3] = 0;
    checks++; if (lat !== 16) begin errors++; $display("FAIL imag_latency got %0d exp 16", lat); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_r[k] !== er[k] || o_i[k] !== ei[k]) begin
        errors++; $display("FAIL imag_out%0d got (%0d,%0d) exp (%0d,%0d)", k, $signed(o_r[k]), $signed(o_i[k]), er[k], ei[k]);
      end
    end
    release_out();
  endtask

  // x0=-1, x1=+1: row j = (-1 + i^j)/2 in Q5.
  task automatic test_negative();
    int lat;
    run_vec(-1, 0, 1, 0, 0, 0, 0, 0, lat);
    er[0] = 0;   ei[0] = 0;
    er[1] = -16; ei[1] = 16;
    er[2] = -32; ei[2] = 0;
    er[3] = -16; ei[3] = -16;
    checks++; if (lat !== 16) begin errors++; $display("FAIL negative_latency got %0d exp 16", lat); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_r[k] !== er[k] || o_i[k] !== ei[k]) begin
        errors++; $display("FAIL negative_out%0d got (%0d,%0d) exp (%0d,%0d)", k, $signed(o_r[k]), $signed(o_i[k]), er[k], ei[k]);
      end
    end
    release_out();
  endtask

  task automatic test_overflow();
    int lat;
    run_vec(127, 0, 127, 0, 127, 0, 127, 0, lat);
`ifdef QFT_SAT_EN
    er[0] = 4095;
`else
    er[0] = -64;
`endif
    ei[0] = 0; er[1] = 0; ei[1] = 0; er[2] = 0; ei[2] = 0; er[3] = 0; ei[3] = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_r[k] !== er[k] || o_i[k] !== ei[k]) begin
        errors++; $display("FAIL overflow_out%0d got (%0d,%0d) exp (%0d,%0d)", k, $signed(o_r[k]), $signed(o_i[k]), er[k], ei[k]);
      end
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL overflow_ovf got %b exp 1", ovf); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_vec(1, 0, 1, 0, 1, 0, 1, 0, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL stall_first_latency got %0d exp 16", lat); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL stall_ovf_cleared got %b exp 0", ovf); end
    // Second vector offered while the first result is stalled.
    load_vec(10, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || o_r[0] !== 13'd64 || o_r[1] !== 13'd0 || o_i[0] !== 13'd0) begin
        errors++; $display("FAIL stall_hold cycle %0d out_valid=%b in_ready=%b out_r0=%0d exp 1/0/64", c, out_valid, in_ready, $signed(o_r[0]));
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release busy=%b in_ready=%b out_valid=%b exp 0/1/0", busy, in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_second_accept busy=%b exp 1", busy); end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (lat !== 16) begin errors++; $display("FAIL stall_second_latency got %0d exp 16", lat); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_r[k] !== 13'd160 || o_i[k] !== 13'd0) begin
        errors++; $display("FAIL stall_second_out%0d got (%0d,%0d) exp (160,0)", k, $signed(o_r[k]), $signed(o_i[k]));
      end
    end
    release_out();
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen;
    @(negedge clk);
    load_vec(127, 0, 127, 0, 127, 0, 127, 0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle busy=%b in_ready=%b out_valid=%b exp 0/1/0", busy, in_ready, out_valid);
    end
    checks++; if (ovf !== 1'b0 || o_r[0] !== 13'd0 || o_r[3] !== 13'd0) begin
      errors++; $display("FAIL abort_regs ovf=%b out_r0=%0d out_r3=%0d exp 0/0/0", ovf, $signed(o_r[0]), $signed(o_r[3]));
    end
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid got %b exp 0", seen); end
    run_vec(5, 0, 0, 0, 0, 0, 0, 0, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL abort_next_latency got %0d exp 16", lat); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_r[k] !== 13'd80 || o_i[k] !== 13'd0) begin
        errors++; $display("FAIL abort_next_out%0d got (%0d,%0d) exp (80,0)", k, $signed(o_r[k]), $signed(o_i[k]));
      end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL abort_next_ovf got %b exp 0", ovf); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_impulse();
    test_imag();
    test_negative();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
